// File: rtl/dom_rnd_supplier.sv
`default_nettype none
// ============================================================================
// Module   : dom_rnd_supplier
// Brief    : Bank of 32-bit Galois LFSRs producing the fresh Z vector for the
//            DOM shared multipliers. Optional reseed request: RND_RESEED_REQ_EN.
// Revision : 1.0
// ============================================================================
module dom_rnd_supplier #(
    parameter  int SHARES        = 4,
    parameter  int WARMUP_CYCLES = 64,
    parameter  int RESEED_PERIOD = 1024,
    localparam int ZW            = 2 * SHARES * (SHARES - 1)
) (
    input  logic          ClkxCI,
    input  logic          RstxBI,
    input  logic [31:0]   _SeedxDI,
    input  logic          SeedValidxSI,
    output logic          SeedReadyxSO,
    output logic [ZW-1:0] _ZxDO,
    output logic          ZValidxSO,
    input  logic          ZReadyxSI,
    output logic          ReseedReqxSO
);

    localparam int NL  = (ZW + 31) / 32;
    localparam int IW  = (NL > 1) ? $clog2(NL) : 1;
    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [IW-1:0]  IDX_LAST  = IW'(NL - 1);
    localparam logic [WCW-1:0] WARM_LAST = (WARMUP_CYCLES > 0) ? WCW'(WARMUP_CYCLES - 1) : '0;
    localparam logic [31:0]    POLY      = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t           state;
    state_t           after_load;
    logic [NL*32-1:0] lanes;
    logic [NL*32-1:0] lanes_step;
    logic [IW-1:0]    widx;
    logic [WCW-1:0]   wcnt;
    logic             z_valid;
    logic [31:0]      seed_word;
    logic             seed_hs;

    // An all-zero seed would lock a lane at zero forever.
    assign seed_word  = (_SeedxDI == 32'h0) ? 32'h1 : _SeedxDI;
    assign seed_hs    = SeedValidxSI;
    assign after_load = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

    generate
        for (genvar i = 0; i < NL; i++) begin : g_lane
            assign lanes_step[32*i +: 32] = {1'b0, lanes[32*i+31 : 32*i+1]}
                                          ^ (lanes[32*i] ? POLY : 32'h0);
        end
    endgenerate

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state   <= IDLE;
            lanes   <= '0;
            widx    <= '0;
            wcnt    <= '0;
            z_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (seed_hs) begin
                        for (int i = 0; i < NL; i++) begin
                            if (widx == IW'(i)) lanes[32*i +: 32] <= seed_word;
                        end
                        if (widx == IDX_LAST) begin
                            widx    <= '0;
                            wcnt    <= '0;
                            state   <= after_load;
                            z_valid <= (after_load == RUN);
                        end else begin
                            widx  <= widx + IW'(1);
                            state <= LOAD;
                        end
                    end
                end
                WARMUP, RUN: begin
                    if (seed_hs) begin
                        // A seed word mid-stream restarts loading at lane 0.
                        lanes[31:0] <= seed_word;
                        wcnt        <= '0;
                        if (NL == 1) begin
                            widx    <= '0;
                            state   <= after_load;
                            z_valid <= (after_load == RUN);
                        end else begin
                            widx    <= IW'(1);
                            state   <= LOAD;
                            z_valid <= 1'b0;
                        end
                    end else if (state == WARMUP) begin
                        lanes <= lanes_step;
                        if (wcnt == WARM_LAST) begin
                            wcnt    <= '0;
                            state   <= RUN;
                            z_valid <= 1'b1;
                        end else begin
                            wcnt <= wcnt + WCW'(1);
                        end
                    end else if (ZReadyxSI) begin
                        lanes <= lanes_step;
                    end
                end
                default: begin
                    state   <= IDLE;
                    z_valid <= 1'b0;
                end
            endcase
        end
    end

    assign SeedReadyxSO = 1'b1;
    assign ZValidxSO    = z_valid;
    assign _ZxDO        = z_valid ? lanes[ZW-1:0] : '0;

`ifdef RND_RESEED_REQ_EN
    localparam logic [31:0] RP = RESEED_PERIOD;

    logic [15:0] rs_cnt;
    logic        rs_req;
    logic        z_hs;

    assign z_hs = z_valid & ZReadyxSI & ~seed_hs;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            rs_cnt <= '0;
            rs_req <= 1'b0;
        end else if (seed_hs) begin
            rs_cnt <= '0;
            rs_req <= 1'b0;
        end else if (z_hs) begin
            if (rs_cnt != 16'hFFFF) rs_cnt <= rs_cnt + 16'd1;
            if (({16'h0, rs_cnt} + 32'd1) >= RP) rs_req <= 1'b1;
        end
    end

    assign ReseedReqxSO = rs_req;
`else
    assign ReseedReqxSO = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dom_rnd_supplier.sv
`default_nettype none
// Randomized bench for dom_rnd_supplier: three configurations checked against
// a closed-form LFSR model (seed advanced by warmup + handshake count).
module tb_dom_rnd_supplier;

`ifdef RND_RESEED_REQ_EN
    localparam bit REQ_EN = 1'b1;
`else
    localparam bit REQ_EN = 1'b0;
`endif
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] sd_a, sd_b, sd_c;
    logic        sv_a, sv_b, sv_c, zr_a, zr_b, zr_c;
    logic        sr_a, sr_b, sr_c, zv_a, zv_b, zv_c, rq_a, rq_b, rq_c;
    logic [23:0] z_a, z_c;
    logic [39:0] z_b;

    int n_chk  = 0;
    int n_pass = 0;

    dom_rnd_supplier #(.SHARES(4), .WARMUP_CYCLES(2), .RESEED_PERIOD(RP)) dut_a (
        .ClkxCI(clk), .RstxBI(rst_n), ._SeedxDI(sd_a), .SeedValidxSI(sv_a),
        .SeedReadyxSO(sr_a), ._ZxDO(z_a), .ZValidxSO(zv_a), .ZReadyxSI(zr_a),
        .ReseedReqxSO(rq_a));

    dom_rnd_supplier #(.SHARES(5), .WARMUP_CYCLES(0), .RESEED_PERIOD(RP)) dut_b (
        .ClkxCI(clk), .RstxBI(rst_n), ._SeedxDI(sd_b), .SeedValidxSI(sv_b),
        .SeedReadyxSO(sr_b), ._ZxDO(z_b), .ZValidxSO(zv_b), .ZReadyxSI(zr_b),
        .ReseedReqxSO(rq_b));

    dom_rnd_supplier #(.SHARES(4), .WARMUP_CYCLES(0), .RESEED_PERIOD(RP)) dut_c (
        .ClkxCI(clk), .RstxBI(rst_n), ._SeedxDI(sd_c), .SeedValidxSI(sv_c),
        .SeedReadyxSO(sr_c), ._ZxDO(z_c), .ZValidxSO(zv_c), .ZReadyxSI(zr_c),
        .ReseedReqxSO(rq_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] ladv(input logic [31:0] s, input int n);
        logic [31:0] r = s;
        for (int k = 0; k < n; k++) r = lstep(r);
        return r;
    endfunction

    function automatic logic [31:0] fix0(input logic [31:0] w);
        return (w == 32'h0) ? 32'h1 : w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cur, cur0, cur1, w0, w1;
    int          hs;
    bit          r;

    initial begin
        sd_a = '0; sd_b = '0; sd_c = '0;
        sv_a = 0;  sv_b = 0;  sv_c = 0;
        zr_a = 0;  zr_b = 0;  zr_c = 0;
        repeat (3) tick;
        check("rst_zv_a", zv_a, 0);
        check("rst_z_a", z_a, 0);
        check("rst_sr_a", sr_a, 1);
        check("rst_rq_a", rq_a, 0);
        check("rst_zv_b", zv_b, 0);
        check("rst_z_b", z_b, 0);
        check("rst_zv_c", zv_c, 0);
        rst_n = 1;
        tick;

        // --- A: seed 1, warmup 2
        sd_a = 32'h1; sv_a = 1; tick; sv_a = 0;
        check("a_warm0", zv_a, 0);
        check("a_sr", sr_a, 1);
        tick; check("a_warm1", zv_a, 0);
        tick; check("a_valid", zv_a, 1);
        check("a_z0", z_a, 24'h300002);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("a_hold_z", z_a, 24'h300002);
            check("a_hold_v", zv_a, 1);
        end
        zr_a = 1; tick; zr_a = 0;
        check("a_z1", z_a, 24'h180001);

        // --- A: randomized reseeds while running, random consumer
        for (int it = 0; it < 6; it++) begin
            w0 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cur = ladv(fix0(w0), 2);
            sd_a = w0; sv_a = 1; zr_a = 1'($urandom_range(0, 1)); tick;
            sv_a = 0; zr_a = 0;
            check("a_rs_drop", zv_a, 0);
            check("a_rs_z0", z_a, 0);
            check("a_rq_clr", rq_a, 0);
            tick; tick;
            check("a_rs_valid", zv_a, 1);
            hs = 0;
            for (int c = 0; c < 12; c++) begin
                check("a_rnd_z", z_a, cur[23:0]);
                check("a_rnd_v", zv_a, 1);
                check("a_rnd_rq", rq_a, (REQ_EN && hs >= RP));
                r = (($urandom_range(0, 3)) != 0);
                zr_a = r; tick; zr_a = 0;
                if (r) begin cur = lstep(cur); hs++; end
            end
        end

        // --- A: exact reseed-request threshold
        sd_a = 32'h1234_5678; sv_a = 1; tick; sv_a = 0;
        tick; tick;
        cur = ladv(32'h1234_5678, 2);
        for (int c = 1; c <= RP; c++) begin
            zr_a = 1; tick; zr_a = 0;
            cur = lstep(cur);
            check("a_thr_rq", rq_a, (REQ_EN && c >= RP));
            check("a_thr_v", zv_a, 1);
            check("a_thr_z", z_a, cur[23:0]);
        end
        sd_a = 32'h5; sv_a = 1; tick; sv_a = 0;
        check("a_thr_clr", rq_a, 0);

        // --- C: zero seed with no warmup
        sd_c = 32'h0; sv_c = 1; tick; sv_c = 0;
        check("c_v", zv_c, 1);
        check("c_z", z_c, 24'h000001);
        zr_c = 1; tick; zr_c = 0;
        check("c_step", z_c, 24'h200003);

        // --- B: two lanes, no warmup
        sd_b = 32'h1; sv_b = 1; tick; sv_b = 0;
        check("b_one_word", zv_b, 0);
        tick; check("b_one_word2", zv_b, 0);
        sd_b = 32'h2; sv_b = 1; tick; sv_b = 0;
        check("b_valid", zv_b, 1);
        check("b_z0", z_b, 40'h02_00000001);
        for (int it = 0; it < 5; it++) begin
            w0 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            w1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            sd_b = w0; sv_b = 1; zr_b = 1'($urandom_range(0, 1)); tick;
            sv_b = 0; zr_b = 0;
            check("b_rs_drop", zv_b, 0);
            check("b_rq_clr", rq_b, 0);
            repeat ($urandom_range(0, 2)) begin
                zr_b = 1'($urandom_range(0, 1)); tick; zr_b = 0;
                check("b_gap", zv_b, 0);
            end
            sd_b = w1; sv_b = 1; tick; sv_b = 0;
            cur0 = fix0(w0); cur1 = fix0(w1);
            hs = 0;
            for (int c = 0; c < 8; c++) begin
                check("b_rnd_z", z_b, {cur1[7:0], cur0});
                check("b_rnd_v", zv_b, 1);
                check("b_rnd_rq", rq_b, (REQ_EN && hs >= RP));
                r = (($urandom_range(0, 3)) != 0);
                zr_b = r; tick; zr_b = 0;
                if (r) begin cur0 = lstep(cur0); cur1 = lstep(cur1); hs++; end
            end
        end

        // --- asynchronous reset: A running, B mid-load
        sd_a = 32'h1; sv_a = 1; tick; sv_a = 0; tick; tick;
        check("a_pre_rst", zv_a, 1);
        sd_b = 32'hDEAD_BEEF; sv_b = 1; tick; sv_b = 0;
        #3 rst_n = 0;
        #1;
        check("a_async_v", zv_a, 0);
        check("a_async_z", z_a, 0);
        check("c_async_v", zv_c, 0);
        #2 rst_n = 1;
        tick; tick; tick;
        check("a_post_rst", zv_a, 0);
        check("b_post_rst", zv_b, 0);
        sd_b = 32'h5; sv_b = 1; tick;
        sd_b = 32'h6; tick; sv_b = 0;
        check("b_fresh_v", zv_b, 1);
        check("b_fresh_z", z_b, 40'h06_00000005);

        // --- A: reset during warmup discards the seed
        sd_a = 32'h7; sv_a = 1; tick; sv_a = 0; tick;
        #3 rst_n = 0; #3 rst_n = 1;
        tick; tick; tick;
        check("a_warm_rst", zv_a, 0);
        sd_a = 32'h1; sv_a = 1; tick; sv_a = 0; tick; tick;
        check("a_reseed_z", z_a, 24'h300002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
